rptr_empty_prog: RTL and testbench

Read-side pointer and flag generator for the async FIFO, in the rclk domain.
- Generalises the basic read-pointer/empty block: the write-pointer synchroniser is internal with parametrised depth.
- Adds an occupancy level, a programmable almost-empty flag and a sticky underflow flag.
- Sits between the dual-port RAM read address and the read-side consumer; exports the Gray rptr for the write-side synchroniser.

---
 rtl/fifo_ptr_pkg.sv | 27 ++
 rtl/sync_ptr.sv | 35 +++
 rtl/rptr_empty_prog.sv | 98 +++++++++
 tb/tb_rptr_empty_prog.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared helpers and reset values for the async FIFO pointer blocks.
// Contents:
//   bin2gray / gray2bin : 32-bit conversions. Callers zero-extend their
//                         pointer into 32 bits and truncate the result.
//   RST_*               : reset values of the read-side status outputs.
package fifo_ptr_pkg;

  localparam logic RST_REMPTY        = 1'b1;
  localparam logic RST_RALMOST_EMPTY = 1'b1;
  localparam logic RST_RUNDERFLOW    = 1'b0;
  localparam int   RST_RLEVEL        = 0;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ptr.sv
// N-flop synchroniser for a Gray-coded pointer crossing into clk_i.
// Used by both the read side (wptr into rclk) and the write side.
// Ports:
//   clk_i  destination-domain clock
//   rst_i  asynchronous active-high reset, clears every stage
//   d_i    pointer from the other clock domain
//   q_o    synchronised pointer (last stage)
module sync_ptr #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_empty_prog.sv
// Read-side pointer and status generator of the async FIFO (rclk domain).
// Keeps the binary/Gray read pointer, synchronises the write pointer and
// derives empty, occupancy level, almost-empty and sticky underflow.
// Ports:
//   rclk          read clock
//   rrst          asynchronous active-high reset
//   wptr_gray     write-domain Gray pointer (asynchronous)
//   rinc          read request, honoured only while not empty
//   ae_level      almost-empty threshold (quasi-static)
//   uflow_clr     clears runderflow
//   raddr         binary RAM read address
//   rptr          registered Gray read pointer for the write side
//   rempty        FIFO empty
//   ralmost_empty rlevel <= ae_level
//   rlevel        words available, 0..2^ADDRSIZE
//   runderflow    sticky flag: read requested while empty
module rptr_empty_prog
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   ae_level,
  input  logic                uflow_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] rq_wptr;
  logic [ADDRSIZE:0] wbin;

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              rae_q, rae_d;
  logic              runderflow_q, runderflow_d;
  logic              rd_en;

  sync_ptr #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i (rclk),
    .rst_i (rrst),
    .d_i   (wptr_gray),
    .q_o   (rq_wptr)
  );

  always_comb begin
    rd_en        = rinc & ~rempty_q;
    rbin_d       = rbin_q + PW'(rd_en);
    rptr_d       = PW'(bin2gray(32'(rbin_d)));
    wbin         = PW'(gray2bin(32'(rq_wptr)));
    // Modular difference: correct across pointer wrap.
    rlevel_d     = wbin - rbin_d;
    rempty_d     = (rptr_d == rq_wptr);
    rae_d        = (rlevel_d <= ae_level);
    // Set has priority over clear.
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~uflow_clr);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= PW'(RST_RLEVEL);
      rempty_q     <= RST_REMPTY;
      rae_q        <= RST_RALMOST_EMPTY;
      runderflow_q <= RST_RUNDERFLOW;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      rae_q        <= rae_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_prog.sv
module tb_rptr_empty_prog;

  localparam int A = 4;
  localparam int S = 2;
  localparam int DEPTH = 1 << A;

  logic         rclk;
  logic         rrst;
  logic [A:0]   wptr_gray;
  logic         rinc;
  logic [A:0]   ae_level;
  logic         uflow_clr;
  logic [A-1:0] raddr;
  logic [A:0]   rptr;
  logic         rempty;
  logic         ralmost_empty;
  logic [A:0]   rlevel;
  logic         runderflow;

  rptr_empty_prog #(.ADDRSIZE(A), .SYNC_STAGES(S)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .wptr_gray     (wptr_gray),
    .rinc          (rinc),
    .ae_level      (ae_level),
    .uflow_clr     (uflow_clr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial rclk = 1'b1;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counts of words written / read, and the write count
  // as it was S edges ago (what the read side can see).
  int wcount, rcount;
  int wq[$];
  int m_level;
  bit m_empty, m_ae, m_uf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [A:0] gray(input int b);
    logic [A:0] v;
    v = A'(0) + (A+1)'(b & (2*DEPTH-1));
    return v ^ (v >> 1);
  endfunction

  task automatic drive_wptr();
    wptr_gray = gray(wcount);
  endtask

  task automatic model_reset();
    wq.delete();
    for (int i = 0; i < S; i++) wq.push_back(0);
    rcount  = 0;
    m_level = 0;
    m_empty = 1;
    m_ae    = 1;
    m_uf    = 0;
  endtask

  // Called in the low phase; reset takes effect without a clock edge.
  task automatic do_reset();
    rrst = 1'b1;
    wcount = 0;
    drive_wptr();
    rinc = 1'b0;
    uflow_clr = 1'b0;
    #1;
    check_eq("rst_rptr",   32'(rptr), 0);
    check_eq("rst_raddr",  32'(raddr), 0);
    check_eq("rst_rempty", 32'(rempty), 1);
    check_eq("rst_ae",     32'(ralmost_empty), 1);
    check_eq("rst_rlevel", 32'(rlevel), 0);
    check_eq("rst_uflow",  32'(runderflow), 0);
    model_reset();
    #1 rrst = 1'b0;
  endtask

  task automatic step();
    int vis;
    bit rd;
    @(posedge rclk);
    vis = wq.pop_front();
    wq.push_back(wcount);
    rd = rinc && !m_empty;
    m_uf = (rinc && m_empty) || (m_uf && !uflow_clr);
    if (rd) rcount++;
    m_level = (vis - rcount) & (2*DEPTH-1);
    m_empty = (m_level == 0);
    m_ae    = (m_level <= int'(ae_level));
    @(negedge rclk);
    check_eq("rempty",  32'(rempty), 32'(m_empty));
    check_eq("rlevel",  32'(rlevel), 32'(m_level));
    check_eq("ralmost", 32'(ralmost_empty), 32'(m_ae));
    check_eq("uflow",   32'(runderflow), 32'(m_uf));
    check_eq("rptr",    32'(rptr), 32'(gray(rcount)));
    check_eq("raddr",   32'(raddr), 32'(rcount & (DEPTH-1)));
    check_eq("lvl_max", 32'(rlevel <= DEPTH), 1);
  endtask

  initial begin
    int wprob, rprob;
    rrst = 1'b0; rinc = 1'b0; uflow_clr = 1'b0; ae_level = '0;
    wcount = 0; drive_wptr();
    #1 do_reset();

    // First word crosses, then is read.
    ae_level = '0;
    wcount = 1; drive_wptr();
    step(); check_eq("s2_empty_e1", 32'(rempty), 1);
    step(); check_eq("s2_empty_e2", 32'(rempty), 1);
    step(); check_eq("s2_empty_e3", 32'(rempty), 0);
    check_eq("s2_level_e3", 32'(rlevel), 1);
    check_eq("s2_ae_eq_empty", 32'(ralmost_empty), 0);
    rinc = 1'b1;
    step(); rinc = 1'b0;
    check_eq("s2_raddr", 32'(raddr), 1);
    check_eq("s2_rptr", 32'(rptr), 32'h01);
    check_eq("s2_empty", 32'(rempty), 1);
    check_eq("s2_level", 32'(rlevel), 0);

    // Full FIFO drained against an almost-empty threshold of 4.
    do_reset();
    ae_level = 5'd4;
    wcount = 16; drive_wptr();
    check_eq("s3_wptr", 32'(wptr_gray), 32'h18);
    repeat (3) step();
    check_eq("s3_level16", 32'(rlevel), 16);
    check_eq("s3_ae0", 32'(ralmost_empty), 0);
    rinc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_eq("s3_level", 32'(rlevel), 32'(16 - i));
      check_eq("s3_ae", 32'(ralmost_empty), 32'((16 - i) <= 4));
    end
    check_eq("s3_empty", 32'(rempty), 1);
    check_eq("s3_rptr", 32'(rptr), 32'h18);
    // Underflow: pointer holds, flag sets; clear loses to set; clear alone wins.
    step();
    check_eq("s4_rptr_hold", 32'(rptr), 32'h18);
    check_eq("s4_uflow_set", 32'(runderflow), 1);
    uflow_clr = 1'b1;
    step();
    check_eq("s4_set_wins", 32'(runderflow), 1);
    rinc = 1'b0;
    step();
    check_eq("s4_cleared", 32'(runderflow), 0);
    uflow_clr = 1'b0;

    // Reset in the middle of operation, then recovery.
    do_reset();
    ae_level = 5'd2;
    wcount = 7; drive_wptr();
    repeat (3) step();
    check_eq("s6_level7", 32'(rlevel), 7);
    do_reset();
    wcount = 1; drive_wptr();
    step(); step();
    check_eq("s6_empty_e2", 32'(rempty), 1);
    step();
    check_eq("s6_empty_e3", 32'(rempty), 0);

    // Randomised streaming with varying read/write rates.
    wprob = 2; rprob = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        wprob = $urandom_range(0, 4);
        rprob = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 99) == 0) ae_level = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 999) == 0) do_reset();
      rinc = ($urandom_range(0, 3) < rprob);
      uflow_clr = ($urandom_range(0, 15) == 0);
      if (($urandom_range(0, 3) < wprob) && (wcount - rcount < DEPTH)) wcount++;
      drive_wptr();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
